// File: rtl/rom_player_if.sv
// Handshake/bus bundle for rom_player: read/playback controls in, output slot and status out.
interface rom_player_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             start;
    logic             loop;
    logic             stop;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        output rd_en, rd_addr, start, loop, stop, out_ready,
        input  out_valid, out_data, out_addr, out_last, busy, done
    );

    modport slave (
        input  rd_en, rd_addr, start, loop, stop, out_ready,
        output out_valid, out_data, out_addr, out_last, busy, done
    );
endinterface

// File: rtl/rom_player.sv
// Computed ROM (entry i = i ^ MASK) with random reads and sequential/looping playback
// into a single-entry valid/ready output slot.
module rom_player #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 16,
    parameter int               AW    = 4,
    parameter logic [WIDTH-1:0] MASK  = '0
) (
    input logic        CLK,
    input logic        RESET,
    rom_player_if.slave bus
);
    typedef enum logic {IDLE, PLAY} state_e;

    state_e           state_q;
    logic [AW-1:0]    ptr_q;
    logic             loop_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [AW-1:0]    out_addr_q;
    logic             out_last_q;
    logic             done_q;

    logic free;
    logic ptr_at_end;

    // Addresses past the end read as zero; the mask only applies to real entries.
    function automatic logic [WIDTH-1:0] rom_word(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return '0;
        return WIDTH'(32'(a)) ^ MASK;
    endfunction

    assign free       = !out_valid_q || bus.out_ready;
    assign ptr_at_end = (ptr_q == AW'(DEPTH - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            loop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= out_valid_q && bus.out_ready && out_last_q;
            // A load below overrides this drain of a free slot.
            if (free) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= PLAY;
                        ptr_q   <= '0;
                        loop_q  <= bus.loop;
                    end else if (bus.rd_en && free) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rom_word(bus.rd_addr);
                        out_addr_q  <= bus.rd_addr;
                        out_last_q  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                    end else if (free) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rom_word(ptr_q);
                        out_addr_q  <= ptr_q;
                        if (ptr_at_end) begin
                            ptr_q      <= '0;
                            out_last_q <= !loop_q;
                            if (!loop_q) state_q <= IDLE;
                        end else begin
                            ptr_q      <= ptr_q + AW'(1);
                            out_last_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == PLAY);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rom_player.sv
// Randomized + directed bench for rom_player; expected words come from the entry formula
// and the accepted-word sequence, not from the DUT.
module tb_rom_player;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_player_if #(.WIDTH(8), .AW(4)) b0 ();
    rom_player_if #(.WIDTH(8), .AW(4)) b1 ();

    rom_player #(.WIDTH(8), .DEPTH(16), .AW(4), .MASK(8'h00)) dut0 (.CLK(clk), .RESET(rst), .bus(b0.slave));
    rom_player #(.WIDTH(8), .DEPTH(12), .AW(4), .MASK(8'hFF)) dut1 (.CLK(clk), .RESET(rst), .bus(b1.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_word(input int a, input int depth, input logic [7:0] mask);
        if (a >= depth) return 8'h00;
        return 8'(a) ^ mask;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b0.rd_en = 0; b0.rd_addr = '0; b0.start = 0; b0.loop = 0; b0.stop = 0; b0.out_ready = 1;
        b1.rd_en = 0; b1.rd_addr = '0; b1.start = 0; b1.loop = 0; b1.stop = 0; b1.out_ready = 1;
    endtask

    // Non-loop playback on dut0; optional random back-pressure and a forced 3-cycle stall at stall_at.
    task automatic play0(input bit rnd, input int stall_at, input int exp_cyc);
        int k = 0, cyc = 0, dn = 0, stall = 0;
        bit held = 0, r;
        logic [7:0] hd; logic [3:0] ha; logic hl;
        b0.loop = 0; b0.start = 1;
        step();
        b0.start = 0;
        chk("play_busy", b0.busy, 1);
        while (k < 16 && cyc < 400) begin
            if (held) begin
                chk("hold_valid", b0.out_valid, 1);
                chk("hold_data", b0.out_data, hd);
                chk("hold_addr", b0.out_addr, ha);
                chk("hold_last", b0.out_last, hl);
            end
            if (b0.done) dn++;
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (b0.out_valid && int'(b0.out_addr) == stall_at && stall < 3) begin
                r = 0;
                stall++;
            end
            b0.out_ready = r;
            // start/rd_en while playing must be ignored
            b0.rd_en   = b0.busy ? 1'($urandom_range(0, 1)) : 1'b0;
            b0.start   = b0.busy ? 1'($urandom_range(0, 1)) : 1'b0;
            b0.rd_addr = 4'($urandom_range(0, 15));
            held = b0.out_valid && !r;
            hd = b0.out_data; ha = b0.out_addr; hl = b0.out_last;
            if (b0.out_valid && r) begin
                chk("play_data", b0.out_data, ref_word(k, 16, 8'h00));
                chk("play_addr", b0.out_addr, 32'(k));
                chk("play_last", b0.out_last, (k == 15) ? 1 : 0);
                k++;
            end
            step();
            cyc++;
        end
        idle_inputs();
        chk("play_count", k, 16);
        if (exp_cyc > 0) chk("play_cycles", cyc, exp_cyc);
        if (stall_at >= 0) chk("stall_seen", stall, 3);
        chk("done_pulse", b0.done, 1);
        chk("end_busy", b0.busy, 0);
        chk("end_valid", b0.out_valid, 0);
        chk("done_early", dn, 0);
        step();
        chk("done_once", b0.done, 0);
    endtask

    initial begin
        int k, cyc, a;
        bit found;
        rst = 1;
        idle_inputs();
        step(); step();
        chk("rst_valid", b0.out_valid, 0);
        chk("rst_data", b0.out_data, 0);
        chk("rst_addr", b0.out_addr, 0);
        chk("rst_last", b0.out_last, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_done", b0.done, 0);
        chk("rst_valid1", b1.out_valid, 0);
        rst = 0;
        step();

        // Single read of entry 5
        b0.rd_en = 1; b0.rd_addr = 4'd5;
        step();
        b0.rd_en = 0;
        chk("rd5_valid", b0.out_valid, 1);
        chk("rd5_data", b0.out_data, 8'h05);
        chk("rd5_addr", b0.out_addr, 5);
        chk("rd5_last", b0.out_last, 0);
        step();
        chk("rd_drain", b0.out_valid, 0);

        // Random reads on both instances (dut1 reads past DEPTH as 0)
        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 15);
            b0.rd_en = 1; b0.rd_addr = 4'(a);
            b1.rd_en = 1; b1.rd_addr = 4'(a);
            step();
            chk("rrd_data0", b0.out_data, ref_word(a, 16, 8'h00));
            chk("rrd_valid0", b0.out_valid, 1);
            chk("rrd_data1", b1.out_data, ref_word(a, 12, 8'hFF));
            chk("rrd_addr1", b1.out_addr, 32'(a));
        end
        idle_inputs();
        step();

        // Read while slot is full is dropped
        b0.out_ready = 0; b0.rd_en = 1; b0.rd_addr = 4'd3;
        step();
        b0.rd_addr = 4'd7;
        step();
        b0.rd_en = 0;
        chk("drop_data", b0.out_data, 8'h03);
        chk("drop_valid", b0.out_valid, 1);
        b0.out_ready = 1;
        step();
        chk("drop_drain", b0.out_valid, 0);

        // Stop in IDLE has no effect
        b0.stop = 1; b0.rd_en = 1; b0.rd_addr = 4'd9;
        step();
        idle_inputs();
        chk("idle_stop_data", b0.out_data, 8'h09);
        chk("idle_stop_busy", b0.busy, 0);
        step();

        play0(0, -1, 17);
        play0(0, 7, 20);
        play0(1, 7, 0);

        // Looping playback on the masked 12-entry instance
        b1.loop = 1; b1.start = 1;
        step();
        b1.start = 0; b1.loop = 0;
        k = 0; cyc = 0;
        while (k < 30 && cyc < 100) begin
            if (b1.out_valid) begin
                chk("loop_data", b1.out_data, ref_word(k % 12, 12, 8'hFF));
                chk("loop_addr", b1.out_addr, 32'(k % 12));
                chk("loop_last", b1.out_last, 0);
                k++;
            end
            chk("loop_done", b1.done, 0);
            step();
            cyc++;
        end
        chk("loop_count", k, 30);
        chk("loop_busy", b1.busy, 1);
        chk("loop_pending", b1.out_data, ref_word(30 % 12, 12, 8'hFF));
        b1.stop = 1;
        step();
        b1.stop = 0;
        chk("stop_busy", b1.busy, 0);
        chk("stop_valid", b1.out_valid, 0);
        step();
        chk("stop_done", b1.done, 0);

        // Reset in mid-playback at word 9
        b0.start = 1;
        step();
        b0.start = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (b0.out_valid && b0.out_data == 8'h09) found = 1;
            else step();
        end
        chk("wait_word9", found, 1);
        rst = 1;
        step();
        rst = 0;
        chk("mrst_valid", b0.out_valid, 0);
        chk("mrst_busy", b0.busy, 0);
        chk("mrst_data", b0.out_data, 0);
        chk("mrst_last", b0.out_last, 0);
        step();
        chk("mrst_idle", b0.out_valid, 0);

        // start beats rd_en in the same cycle
        b0.start = 1; b0.rd_en = 1; b0.rd_addr = 4'd5; b0.loop = 0;
        step();
        idle_inputs();
        chk("sr_valid", b0.out_valid, 0);
        chk("sr_busy", b0.busy, 1);
        step();
        chk("sr_data", b0.out_data, 8'h00);
        chk("sr_addr", b0.out_addr, 0);
        b0.stop = 1;
        step();
        b0.stop = 0;
        chk("sr_stop_busy", b0.busy, 0);
        chk("sr_stop_valid", b0.out_valid, 0);
        step();
        chk("sr_stop_done", b0.done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
